// File: rtl/pagerank_pkg.sv
// Shared types and fixed-point helpers for the serial PageRank gather path.
// Contents:
//   q16_t           unsigned Q16.16 value
//   Q_ONE           1.0 in Q16.16
//   gather_state_t  gather FSM states
//   q_mul_sat       Q16.16 multiply (64-bit product >> 16), saturating
//   q_add_sat       unsigned add, saturating at all-ones
package pagerank_pkg;

  typedef logic [31:0] q16_t;

  localparam q16_t Q_ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    G_IDLE,
    G_INIT,
    G_ACCUM,
    G_APPLY,
    G_DONE
  } gather_state_t;

  function automatic q16_t q_mul_sat(input q16_t a, input q16_t b);
    logic [63:0] prod;
    logic [63:0] shifted;
    prod    = {32'd0, a} * {32'd0, b};
    shifted = prod >> 16;
    if (|shifted[63:32]) begin
      return '1;
    end
    return shifted[31:0];
  endfunction

  function automatic q16_t q_add_sat(input q16_t a, input q16_t b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[32]) begin
      return '1;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/pagerank_apply_unit.sv
// Combinational damping step for one node.
// Ports:
//   d        in   damping factor, Q16.16
//   base     in   (1-d)/N, Q16.16
//   acc      in   accumulated contributions for the node
//   old      in   rank before this pass
//   new_rank out  base + sat(d*acc), saturating
//   delta    out  |new_rank - old|
module pagerank_apply_unit
  import pagerank_pkg::*;
(
  input  q16_t d,
  input  q16_t base,
  input  q16_t acc,
  input  q16_t old,
  output q16_t new_rank,
  output q16_t delta
);

  q16_t scaled;

  always_comb begin
    scaled   = q_mul_sat(d, acc);
    new_rank = q_add_sat(base, scaled);
    delta    = (new_rank >= old) ? (new_rank - old) : (old - new_rank);
  end

endmodule

// File: rtl/pagerank_gather_serial.sv
// Gather end of the serial PageRank engine: accumulates (dest_id, contribution)
// beats per node, applies damping one node per cycle, tracks the largest rank
// change and flags convergence. Holds the rank table read back by scatter.
// Ports:
//   clock, reset           clock (rising edge), async active-high reset
//   start                  begin a run from IDLE (samples damping_factor, threshold)
//   damping_factor         Q16.16 d
//   threshold              Q16.16 convergence threshold
//   upd_valid/ready        update stream handshake
//   upd_dest_id            destination node 1..NUM_NODES, 0 = padding
//   upd_contrib            Q16.16 contribution
//   upd_last               final beat of a scatter iteration
//   rank_rd_addr/data      rank read port, 1-cycle registered, 0 for bad address
//   iter_done              pulse at the end of each apply pass
//   converged              valid with iter_done, held until next start
//   iter_count             completed iterations
//   busy                   not idle
//   id_err                 sticky: a beat addressed a node above NUM_NODES
//
// state   | meaning
// --------+---------------------------------------------------------
// G_IDLE  | waiting for start; rank table readable
// G_INIT  | one node per cycle: rank = 1/N, acc = 0
// G_ACCUM | accepting update beats until the last one
// G_APPLY | one node per cycle: rank = base + d*acc, acc = 0
// G_DONE  | one cycle: iter_done, convergence decision
module pagerank_gather_serial
  import pagerank_pkg::*;
#(
  parameter int NUM_NODES = 4,
  parameter int ID_W      = 32,
  parameter int RANK_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [RANK_W-1:0] damping_factor,
  input  logic [RANK_W-1:0] threshold,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ID_W-1:0]   upd_dest_id,
  input  logic [RANK_W-1:0] upd_contrib,
  input  logic              upd_last,
  input  logic [ID_W-1:0]   rank_rd_addr,
  output logic [RANK_W-1:0] rank_rd_data,
  output logic              iter_done,
  output logic              converged,
  output logic [15:0]       iter_count,
  output logic              busy,
  output logic              id_err
);

  localparam int   CNT_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam q16_t RANK_INIT = Q_ONE / q16_t'(NUM_NODES);

  gather_state_t state_q, state_nxt;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] node_idx;
  q16_t             rank_q [NUM_NODES];
  q16_t             acc_q  [NUM_NODES];
  q16_t             d_q, thr_q, maxd_q;
  q16_t             base;
  q16_t             new_rank, delta;
  q16_t             rd_val;
  logic             converged_q;
  logic             conv_now;
  logic             beat_fire;
  logic             dest_hi;
  logic [NUM_NODES-1:0] dest_hit;

  // Down-counter runs N-1..0; nodes are visited in ascending ID order.
  assign node_idx  = CNT_W'(NUM_NODES - 1) - cnt_q;
  assign base      = (Q_ONE - d_q) / q16_t'(NUM_NODES);
  assign beat_fire = upd_valid && upd_ready;
  assign dest_hi   = upd_dest_id > ID_W'(NUM_NODES);
  assign conv_now  = maxd_q < thr_q;

  pagerank_apply_unit u_apply (
    .d        (d_q),
    .base     (base),
    .acc      (acc_q[node_idx]),
    .old      (rank_q[node_idx]),
    .new_rank (new_rank),
    .delta    (delta)
  );

  always_comb begin
    dest_hit = '0;
    rd_val   = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      if (upd_dest_id == ID_W'(i + 1)) dest_hit[i] = 1'b1;
      if (rank_rd_addr == ID_W'(i + 1)) rd_val = rank_q[i];
    end
  end

  always_comb begin
    state_nxt = state_q;
    upd_ready = 1'b0;
    iter_done = 1'b0;
    busy      = (state_q != G_IDLE);
    converged = converged_q;
    case (state_q)
      G_IDLE:  if (start) state_nxt = G_INIT;
      G_INIT:  if (cnt_q == '0) state_nxt = G_ACCUM;
      G_ACCUM: begin
        upd_ready = 1'b1;
        if (upd_valid && upd_last) state_nxt = G_APPLY;
      end
      G_APPLY: if (cnt_q == '0) state_nxt = G_DONE;
      G_DONE: begin
        iter_done = 1'b1;
        converged = conv_now;
        state_nxt = conv_now ? G_IDLE : G_ACCUM;
      end
      default: state_nxt = G_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= G_IDLE;
      cnt_q        <= '0;
      d_q          <= '0;
      thr_q        <= '0;
      maxd_q       <= '0;
      iter_count   <= '0;
      converged_q  <= 1'b0;
      id_err       <= 1'b0;
      rank_rd_data <= '0;
      for (int i = 0; i < NUM_NODES; i++) begin
        rank_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_nxt;
      rank_rd_data <= rd_val;
      case (state_q)
        G_IDLE: begin
          if (start) begin
            d_q         <= damping_factor;
            thr_q       <= threshold;
            cnt_q       <= CNT_W'(NUM_NODES - 1);
            iter_count  <= '0;
            converged_q <= 1'b0;
            id_err      <= 1'b0;
          end
        end
        G_INIT: begin
          rank_q[node_idx] <= RANK_INIT;
          acc_q[node_idx]  <= '0;
          cnt_q            <= cnt_q - 1'b1;
        end
        G_ACCUM: begin
          if (beat_fire) begin
            for (int i = 0; i < NUM_NODES; i++) begin
              if (dest_hit[i]) acc_q[i] <= q_add_sat(acc_q[i], upd_contrib);
            end
            if (dest_hi) id_err <= 1'b1;
            if (upd_last) begin
              maxd_q <= '0;
              cnt_q  <= CNT_W'(NUM_NODES - 1);
            end
          end
        end
        G_APPLY: begin
          rank_q[node_idx] <= new_rank;
          acc_q[node_idx]  <= '0;
          if (delta > maxd_q) maxd_q <= delta;
          cnt_q <= cnt_q - 1'b1;
        end
        G_DONE: begin
          iter_count  <= iter_count + 16'd1;
          converged_q <= conv_now;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_gather_serial.sv
module tb_pagerank_gather_serial;
  import pagerank_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] damping_factor;
  logic [31:0] threshold;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_dest_id;
  logic [31:0] upd_contrib;
  logic        upd_last;
  logic [31:0] rank_rd_addr;
  logic [31:0] rank_rd_data;
  logic        iter_done;
  logic        converged;
  logic [15:0] iter_count;
  logic        busy;
  logic        id_err;

  int n_checks = 0;
  int n_errors = 0;

  pagerank_gather_serial #(.NUM_NODES(4), .ID_W(32), .RANK_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .damping_factor (damping_factor),
    .threshold      (threshold),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_dest_id    (upd_dest_id),
    .upd_contrib    (upd_contrib),
    .upd_last       (upd_last),
    .rank_rd_addr   (rank_rd_addr),
    .rank_rd_data   (rank_rd_data),
    .iter_done      (iter_done),
    .converged      (converged),
    .iter_count     (iter_count),
    .busy           (busy),
    .id_err         (id_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_rank(input int node, input logic [31:0] exp, input string tag);
    rank_rd_addr = node;
    tick();
    chk(tag, rank_rd_data, exp);
  endtask

  task automatic send_beat(input logic [31:0] dest, input logic [31:0] contrib, input logic last);
    int n;
    upd_valid   = 1'b1;
    upd_dest_id = dest;
    upd_contrib = contrib;
    upd_last    = last;
    n = 0;
    while (!upd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("beat_accept_timeout", 32'(n < 50), 32'd1);
    tick();
    upd_valid = 1'b0;
    upd_last  = 1'b0;
  endtask

  // Runs a bounded window after the last beat; reports iter_done pulses and
  // the converged flag seen alongside the pulse.
  task automatic wait_done(output int pulses, output logic conv);
    pulses = 0;
    conv   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (iter_done) begin
        pulses++;
        conv = converged;
      end
    end
  endtask

  task automatic do_start(input logic [31:0] d, input logic [31:0] thr);
    damping_factor = d;
    threshold      = thr;
    start          = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    tick(); tick(); tick();
    chk("ready_in_init", 32'(upd_ready), 32'd0);
    tick();
    chk("ready_in_accum", 32'(upd_ready), 32'd1);
  endtask

  initial begin
    int   pulses;
    logic conv;
    int   stall;

    reset = 1'b1; start = 1'b0; damping_factor = '0; threshold = '0;
    upd_valid = 1'b0; upd_dest_id = '0; upd_contrib = '0; upd_last = 1'b0;
    rank_rd_addr = 32'd1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(upd_ready), 32'd0);
    chk("rst_iter_done", 32'(iter_done), 32'd0);
    chk("rst_converged", 32'(converged), 32'd0);
    chk("rst_iter_count", 32'(iter_count), 32'd0);
    chk("rst_id_err", 32'(id_err), 32'd0);
    chk("rst_rank", rank_rd_data, 32'd0);
    reset = 1'b0;
    tick();

    // Init: every rank = 1/4 = 0x4000
    do_start(32'h0000_D99A, 32'h0000_0001);
    for (int i = 1; i <= 4; i++) read_rank(i, 32'h0000_4000, $sformatf("init_rank%0d", i));
    read_rank(0, 32'd0, "addr0_rank");
    read_rank(5, 32'd0, "addr5_rank");

    // Single update: node2 = 0x999 + (0xD99A*0x8000)>>16 = 0x999 + 0x6CCD = 0x7666
    send_beat(32'd2, 32'h0000_8000, 1'b1);
    wait_done(pulses, conv);
    chk("single_pulses", 32'(pulses), 32'd1);
    chk("single_conv", 32'(conv), 32'd0);
    chk("single_iter_count", 32'(iter_count), 32'd1);
    read_rank(1, 32'h0000_0999, "single_rank1");
    read_rank(2, 32'h0000_7666, "single_rank2");
    read_rank(3, 32'h0000_0999, "single_rank3");
    read_rank(4, 32'h0000_0999, "single_rank4");

    // Padding then out-of-range: nothing accumulated
    send_beat(32'd0, 32'h0000_FFFF, 1'b0);
    chk("pad_no_id_err", 32'(id_err), 32'd0);
    send_beat(32'd7, 32'h0000_FFFF, 1'b1);
    chk("bad_id_err", 32'(id_err), 32'd1);
    wait_done(pulses, conv);
    chk("pad_pulses", 32'(pulses), 32'd1);
    chk("pad_iter_count", 32'(iter_count), 32'd2);
    for (int i = 1; i <= 4; i++) read_rank(i, 32'h0000_0999, $sformatf("pad_rank%0d", i));

    // Backpressure: next beat held through APPLY (4) + DONE (1)
    send_beat(32'd1, 32'h0000_1000, 1'b1);
    upd_valid = 1'b1; upd_dest_id = 32'd3; upd_contrib = 32'h0000_2000; upd_last = 1'b1;
    stall = 0;
    while (!upd_ready && stall < 50) begin
      tick();
      stall++;
    end
    chk("bp_stall_cycles", 32'(stall), 32'd5);
    chk("bp_iter_count", 32'(iter_count), 32'd3);
    read_rank(1, 32'h0000_1732, "bp_rank1_prev");
    upd_valid = 1'b0; upd_last = 1'b0;
    wait_done(pulses, conv);
    chk("bp_pulses", 32'(pulses), 32'd1);
    // 0x999 + (0xD99A*0x2000)>>16 = 0x999 + 0x1B33
    read_rank(3, 32'h0000_24CC, "bp_rank3_once");
    read_rank(1, 32'h0000_0999, "bp_rank1");

    // start outside IDLE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("start_ignored_ready", 32'(upd_ready), 32'd1);
    chk("start_ignored_count", 32'(iter_count), 32'd4);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Convergence: each node gets 0x4000. Truncation gives
    // 0x999 + 0x3666 = 0x3FFF, so maxd = 1; threshold 2 converges.
    do_start(32'h0000_D99A, 32'h0000_0002);
    send_beat(32'd1, 32'h0000_4000, 1'b0);
    send_beat(32'd2, 32'h0000_4000, 1'b0);
    send_beat(32'd3, 32'h0000_4000, 1'b0);
    send_beat(32'd4, 32'h0000_4000, 1'b1);
    wait_done(pulses, conv);
    chk("conv_pulses", 32'(pulses), 32'd1);
    chk("conv_flag_with_done", 32'(conv), 32'd1);
    chk("conv_sticky", 32'(converged), 32'd1);
    chk("conv_busy", 32'(busy), 32'd0);
    chk("conv_ready", 32'(upd_ready), 32'd0);
    chk("conv_iter_count", 32'(iter_count), 32'd1);
    for (int i = 1; i <= 4; i++) read_rank(i, 32'h0000_3FFF, $sformatf("conv_rank%0d", i));

    // Saturation: 2 x 0xFFFF0000 -> acc 0xFFFFFFFF;
    // rank1 = 0x999 + (0xFFFFFFFF*0xD99A)>>16 = 0x999 + 0xD999FFFF
    do_start(32'h0000_D99A, 32'h0000_0001);
    chk("restart_conv_clear", 32'(converged), 32'd0);
    send_beat(32'd1, 32'hFFFF_0000, 1'b0);
    send_beat(32'd1, 32'hFFFF_0000, 1'b1);
    wait_done(pulses, conv);
    chk("sat_pulses", 32'(pulses), 32'd1);
    read_rank(1, 32'hD99A_0998, "sat_rank1");
    read_rank(2, 32'h0000_0999, "sat_rank2");

    // Reset during APPLY
    send_beat(32'd2, 32'h0000_8000, 1'b1);
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(upd_ready), 32'd0);
    chk("mid_rst_iter_done", 32'(iter_done), 32'd0);
    chk("mid_rst_iter_count", 32'(iter_count), 32'd0);
    chk("mid_rst_rank_data", rank_rd_data, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) read_rank(i, 32'd0, $sformatf("post_rst_rank%0d", i));
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
